// File: rtl/pcie_lane_striper.sv
// Byte striper from the Data Link Layer word stream onto 1..NUM_LANES lanes.
// Optional PAD fill of partial flush groups is enabled by defining PCIE_STRIPE_PAD_EN.
module pcie_lane_striper #(
  parameter int MAC_FRAME_WIDTH = 32,
  parameter int NUM_LANES       = 4,
  parameter int BUF_BYTES       = 2 * (((MAC_FRAME_WIDTH / 8) > NUM_LANES) ?
                                       (MAC_FRAME_WIDTH / 8) : NUM_LANES)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [$clog2(NUM_LANES):0]   link_width_i,
  input  logic [MAC_FRAME_WIDTH-1:0]   mac_data_frame_i,
  input  logic                         mac_data_frame_last_i,
  input  logic                         mac_data_frame_valid_i,
  output logic                         mac_data_frame_ready_o,
  output logic [NUM_LANES*8-1:0]       lane_data_o,
  output logic [NUM_LANES-1:0]         lane_k_o,
  output logic [NUM_LANES-1:0]         lane_valid_o,
  input  logic                         lane_ready_i,
  output logic                         busy_o
);

  localparam int BYTES     = MAC_FRAME_WIDTH / 8;
  localparam int LOG_LANES = $clog2(NUM_LANES);
  localparam int LWW       = LOG_LANES + 1;
  localparam int CW        = $clog2(BUF_BYTES + 1);
  localparam int IW        = (BUF_BYTES > 1) ? $clog2(BUF_BYTES) : 1;
  localparam int BIW       = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t                  state_q;
  logic [CW-1:0]           count_q, count_d;
  logic [7:0]              buf_q [BUF_BYTES];
  logic [7:0]              buf_d [BUF_BYTES];
  logic [7:0]              macByte [BYTES];
  logic [CW-1:0]           nLanes_q, laneSel;
  logic [NUM_LANES*8-1:0]  outData_q, grpData;
  logic [NUM_LANES-1:0]    outValid_q, grpValid;
  logic [CW-1:0]           free, popCnt, remain;
  logic                    push, load, outEmpty;
`ifdef PCIE_STRIPE_PAD_EN
  logic [NUM_LANES-1:0]    outK_q, grpK;
`endif

  // Ready is a function of state and fill level only, never of the incoming valid.
  assign free                   = CW'(BUF_BYTES) - count_q;
  assign mac_data_frame_ready_o = !rst_i && (state_q != FLUSH) && (free >= CW'(BYTES));
  assign push                   = mac_data_frame_valid_i && mac_data_frame_ready_o;
  assign outEmpty               = ~|outValid_q;
  assign load                   = outEmpty || lane_ready_i;

  always_comb begin
    if (link_width_i >= LWW'(LOG_LANES)) laneSel = CW'(NUM_LANES);
    else                                 laneSel = CW'(1) << link_width_i;
  end

  always_comb begin
    for (int k = 0; k < BYTES; k++) macByte[k] = mac_data_frame_i[8*k +: 8];
  end

  // Lane i always takes buffer byte i; a partial group only forms while flushing.
  always_comb begin
    popCnt   = '0;
    grpData  = '0;
    grpValid = '0;
`ifdef PCIE_STRIPE_PAD_EN
    grpK     = '0;
`endif
    if (load) begin
      if (count_q >= nLanes_q)                       popCnt = nLanes_q;
      else if ((state_q == FLUSH) && (count_q != '0)) popCnt = count_q;
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if (CW'(i) < popCnt) begin
        grpData[8*i +: 8] = buf_q[i];
        grpValid[i]       = 1'b1;
      end
`ifdef PCIE_STRIPE_PAD_EN
      else if ((popCnt != '0) && (CW'(i) < nLanes_q)) begin
        grpData[8*i +: 8] = 8'hF7;
        grpK[i]           = 1'b1;
        grpValid[i]       = 1'b1;
      end
`endif
    end
  end

  // Surviving bytes shift down by the popped amount; a pushed word lands right behind them.
  always_comb begin
    remain = count_q - popCnt;
    for (int j = 0; j < BUF_BYTES; j++) begin
      buf_d[j] = buf_q[j];
      if (CW'(j) < remain) begin
        buf_d[j] = buf_q[IW'(j) + IW'(popCnt)];
      end else if (push && (CW'(j) < remain + CW'(BYTES))) begin
        buf_d[j] = macByte[BIW'(CW'(j) - remain)];
      end
    end
    count_d = remain + (push ? CW'(BYTES) : '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      count_q    <= '0;
      nLanes_q   <= CW'(1);
      outData_q  <= '0;
      outValid_q <= '0;
`ifdef PCIE_STRIPE_PAD_EN
      outK_q     <= '0;
`endif
    end else begin
      count_q <= count_d;
      buf_q   <= buf_d;
      if (load) begin
        outData_q  <= grpData;
        outValid_q <= grpValid;
`ifdef PCIE_STRIPE_PAD_EN
        outK_q     <= grpK;
`endif
      end
      // Link width is captured only when a frame starts and then held until IDLE.
      case (state_q)
        IDLE: begin
          if (push) begin
            nLanes_q <= laneSel;
            state_q  <= mac_data_frame_last_i ? FLUSH : STREAM;
          end
        end
        STREAM: begin
          if (push && mac_data_frame_last_i) state_q <= FLUSH;
        end
        FLUSH: begin
          if ((count_q == '0) && load) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lane_data_o  = outData_q;
  assign lane_valid_o = outValid_q;
  assign busy_o       = (state_q != IDLE);
`ifdef PCIE_STRIPE_PAD_EN
  assign lane_k_o     = outK_q;
`else
  assign lane_k_o     = '0;
`endif

endmodule
